// File: rtl/qpu_exu_alu_arbiter.sv
// Shares the single EXU ALU datapath among the ALU, BJP, LSU and QIU requesters and
// registers each datapath result into a per-requester response slot.
module qpu_exu_alu_arbiter #(
  parameter int XLEN     = 32,
  parameter bit ARB_MODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_i_valid,
  output logic            alu_i_ready,
  input  logic [XLEN-1:0] alu_i_op1,
  input  logic [XLEN-1:0] alu_i_op2,
  input  logic [4:0]      alu_i_opsel,
  input  logic            bjp_i_valid,
  output logic            bjp_i_ready,
  input  logic [XLEN-1:0] bjp_i_op1,
  input  logic [XLEN-1:0] bjp_i_op2,
  input  logic [3:0]      bjp_i_cmp,
  input  logic            lsu_i_valid,
  output logic            lsu_i_ready,
  input  logic [XLEN-1:0] lsu_i_op1,
  input  logic [XLEN-1:0] lsu_i_op2,
  input  logic            qiu_i_valid,
  output logic            qiu_i_ready,
  input  logic [XLEN-1:0] qiu_i_op1,
  input  logic [XLEN-1:0] qiu_i_op2,
  output logic            alu_o_valid,
  output logic [XLEN-1:0] alu_o_res,
  input  logic            alu_o_ready,
  output logic            bjp_o_valid,
  output logic            bjp_o_res,
  input  logic            bjp_o_ready,
  output logic            lsu_o_valid,
  output logic [XLEN-1:0] lsu_o_res,
  input  logic            lsu_o_ready,
  output logic            qiu_o_valid,
  output logic [XLEN-1:0] qiu_o_res,
  input  logic            qiu_o_ready,
  output logic            dp_alu_req,
  output logic            dp_bjp_req,
  output logic            dp_lsu_req,
  output logic            dp_qiu_req,
  output logic [XLEN-1:0] dp_alu_op1,
  output logic [XLEN-1:0] dp_alu_op2,
  output logic [XLEN-1:0] dp_bjp_op1,
  output logic [XLEN-1:0] dp_bjp_op2,
  output logic [XLEN-1:0] dp_lsu_op1,
  output logic [XLEN-1:0] dp_lsu_op2,
  output logic [XLEN-1:0] dp_qiu_op1,
  output logic [XLEN-1:0] dp_qiu_op2,
  output logic            dp_alu_add,
  output logic            dp_alu_sub,
  output logic            dp_alu_or,
  output logic            dp_alu_xor,
  output logic            dp_alu_and,
  output logic            dp_bjp_cmp_eq,
  output logic            dp_bjp_cmp_ne,
  output logic            dp_bjp_cmp_lt,
  output logic            dp_bjp_cmp_gt,
  input  logic [XLEN-1:0] dp_alu_res,
  input  logic [XLEN-1:0] dp_lsu_res,
  input  logic [XLEN-1:0] dp_qiu_res,
  input  logic            dp_bjp_cmp_res,
  output logic [1:0]      dbg_rr_ptr
);

  // Handshakes: a request transfers when i_valid & i_ready on a rising edge; i_ready is a
  // combinational function of i_valid, so requesters must never wait for ready before valid.
  // A response is consumed when o_valid & o_ready on a rising edge.

  // Requester index order: ALU=0, BJP=1, LSU=2, QIU=3.
  logic [3:0] in_valid, out_ready, resp_valid_q, busy, eligible, grant;
  logic [1:0] rr_ptr_q, scan_idx, grant_idx;

  assign in_valid  = {qiu_i_valid, lsu_i_valid, bjp_i_valid, alu_i_valid};
  assign out_ready = {qiu_o_ready, lsu_o_ready, bjp_o_ready, alu_o_ready};
  // A slot whose response is being drained this cycle can be refilled in the same cycle.
  assign busy      = resp_valid_q & ~out_ready;
  assign eligible  = in_valid & ~busy;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    if (!rst) begin
      if (ARB_MODE) begin
        for (int k = 0; k < 4; k++) begin
          scan_idx = rr_ptr_q + 2'(k);
          if (grant == '0 && eligible[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
          end
        end
      end else begin
        if (eligible[1])      begin grant[1] = 1'b1; grant_idx = 2'd1; end
        else if (eligible[3]) begin grant[3] = 1'b1; grant_idx = 2'd3; end
        else if (eligible[2]) begin grant[2] = 1'b1; grant_idx = 2'd2; end
        else if (eligible[0]) begin grant[0] = 1'b1; grant_idx = 2'd0; end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (ARB_MODE && grant != '0) begin
      rr_ptr_q <= grant_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      alu_o_res    <= '0;
      bjp_o_res    <= 1'b0;
      lsu_o_res    <= '0;
      qiu_o_res    <= '0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (grant[r])          resp_valid_q[r] <= 1'b1;
        else if (out_ready[r]) resp_valid_q[r] <= 1'b0;
      end
      if (grant[0]) alu_o_res <= dp_alu_res;
      if (grant[1]) bjp_o_res <= dp_bjp_cmp_res;
      if (grant[2]) lsu_o_res <= dp_lsu_res;
      if (grant[3]) qiu_o_res <= dp_qiu_res;
    end
  end

  assign {qiu_o_valid, lsu_o_valid, bjp_o_valid, alu_o_valid} = resp_valid_q;
  assign {qiu_i_ready, lsu_i_ready, bjp_i_ready, alu_i_ready} = grant;
  assign {dp_qiu_req, dp_lsu_req, dp_bjp_req, dp_alu_req}     = grant;
  assign dbg_rr_ptr = rr_ptr_q;

  // Non-granted requesters see all-zero operands and controls on the datapath.
  assign dp_alu_op1 = grant[0] ? alu_i_op1 : '0;
  assign dp_alu_op2 = grant[0] ? alu_i_op2 : '0;
  assign dp_bjp_op1 = grant[1] ? bjp_i_op1 : '0;
  assign dp_bjp_op2 = grant[1] ? bjp_i_op2 : '0;
  assign dp_lsu_op1 = grant[2] ? lsu_i_op1 : '0;
  assign dp_lsu_op2 = grant[2] ? lsu_i_op2 : '0;
  assign dp_qiu_op1 = grant[3] ? qiu_i_op1 : '0;
  assign dp_qiu_op2 = grant[3] ? qiu_i_op2 : '0;
  assign {dp_alu_add, dp_alu_sub, dp_alu_or, dp_alu_xor, dp_alu_and} =
    grant[0] ? alu_i_opsel : 5'b0;
  assign {dp_bjp_cmp_eq, dp_bjp_cmp_ne, dp_bjp_cmp_lt, dp_bjp_cmp_gt} =
    grant[1] ? bjp_i_cmp : 4'b0;

endmodule

// File: tb/tb_qpu_exu_alu_arbiter.sv
// Bench for qpu_exu_alu_arbiter: directed scenarios on a round-robin and a fixed-priority
// instance, then random traffic against a queue-free behavioural model.
module tb_qpu_exu_alu_arbiter;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic alu_i_valid, bjp_i_valid, lsu_i_valid, qiu_i_valid;
  logic alu_i_ready, bjp_i_ready, lsu_i_ready, qiu_i_ready;
  logic [XLEN-1:0] alu_i_op1, alu_i_op2, bjp_i_op1, bjp_i_op2;
  logic [XLEN-1:0] lsu_i_op1, lsu_i_op2, qiu_i_op1, qiu_i_op2;
  logic [4:0] alu_i_opsel;
  logic [3:0] bjp_i_cmp;
  logic alu_o_valid, bjp_o_valid, lsu_o_valid, qiu_o_valid;
  logic [XLEN-1:0] alu_o_res, lsu_o_res, qiu_o_res;
  logic bjp_o_res;
  logic alu_o_ready, bjp_o_ready, lsu_o_ready, qiu_o_ready;
  logic dp_alu_req, dp_bjp_req, dp_lsu_req, dp_qiu_req;
  logic [XLEN-1:0] dp_alu_op1, dp_alu_op2, dp_bjp_op1, dp_bjp_op2;
  logic [XLEN-1:0] dp_lsu_op1, dp_lsu_op2, dp_qiu_op1, dp_qiu_op2;
  logic dp_alu_add, dp_alu_sub, dp_alu_or, dp_alu_xor, dp_alu_and;
  logic dp_bjp_cmp_eq, dp_bjp_cmp_ne, dp_bjp_cmp_lt, dp_bjp_cmp_gt;
  logic [XLEN-1:0] dp_alu_res, dp_lsu_res, dp_qiu_res;
  logic dp_bjp_cmp_res;
  logic [1:0] dbg_rr_ptr;

  logic [3:0] rdy, ov;
  assign rdy = {qiu_i_ready, lsu_i_ready, bjp_i_ready, alu_i_ready};
  assign ov  = {qiu_o_valid, lsu_o_valid, bjp_o_valid, alu_o_valid};

  // Fixed-priority instance: shares all inputs, its datapath results are tied to zero.
  wire [3:0]      f_rdy, f_ov, f_req, f_cmp_ctl;
  wire [4:0]      f_alu_ctl;
  wire [XLEN-1:0] f_res [3];
  wire            f_bjp_res;
  wire [XLEN-1:0] f_op1 [4];
  wire [XLEN-1:0] f_op2 [4];
  wire [1:0]      f_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Stand-in for the external ALU datapath.
  always_comb begin
    dp_alu_res = ({XLEN{dp_alu_add}} & (dp_alu_op1 + dp_alu_op2))
               | ({XLEN{dp_alu_sub}} & (dp_alu_op1 - dp_alu_op2))
               | ({XLEN{dp_alu_or}}  & (dp_alu_op1 | dp_alu_op2))
               | ({XLEN{dp_alu_xor}} & (dp_alu_op1 ^ dp_alu_op2))
               | ({XLEN{dp_alu_and}} & (dp_alu_op1 & dp_alu_op2));
    dp_lsu_res = dp_lsu_op1 + dp_lsu_op2;
    dp_qiu_res = dp_qiu_op1 + dp_qiu_op2;
    dp_bjp_cmp_res = (dp_bjp_cmp_eq & (dp_bjp_op1 == dp_bjp_op2))
                   | (dp_bjp_cmp_ne & (dp_bjp_op1 != dp_bjp_op2))
                   | (dp_bjp_cmp_lt & ($signed(dp_bjp_op1) <  $signed(dp_bjp_op2)))
                   | (dp_bjp_cmp_gt & ($signed(dp_bjp_op1) >= $signed(dp_bjp_op2)));
  end

  qpu_exu_alu_arbiter #(.XLEN(XLEN), .ARB_MODE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .alu_i_valid(alu_i_valid), .alu_i_ready(alu_i_ready), .alu_i_op1(alu_i_op1),
    .alu_i_op2(alu_i_op2), .alu_i_opsel(alu_i_opsel),
    .bjp_i_valid(bjp_i_valid), .bjp_i_ready(bjp_i_ready), .bjp_i_op1(bjp_i_op1),
    .bjp_i_op2(bjp_i_op2), .bjp_i_cmp(bjp_i_cmp),
    .lsu_i_valid(lsu_i_valid), .lsu_i_ready(lsu_i_ready), .lsu_i_op1(lsu_i_op1),
    .lsu_i_op2(lsu_i_op2),
    .qiu_i_valid(qiu_i_valid), .qiu_i_ready(qiu_i_ready), .qiu_i_op1(qiu_i_op1),
    .qiu_i_op2(qiu_i_op2),
    .alu_o_valid(alu_o_valid), .alu_o_res(alu_o_res), .alu_o_ready(alu_o_ready),
    .bjp_o_valid(bjp_o_valid), .bjp_o_res(bjp_o_res), .bjp_o_ready(bjp_o_ready),
    .lsu_o_valid(lsu_o_valid), .lsu_o_res(lsu_o_res), .lsu_o_ready(lsu_o_ready),
    .qiu_o_valid(qiu_o_valid), .qiu_o_res(qiu_o_res), .qiu_o_ready(qiu_o_ready),
    .dp_alu_req(dp_alu_req), .dp_bjp_req(dp_bjp_req), .dp_lsu_req(dp_lsu_req),
    .dp_qiu_req(dp_qiu_req),
    .dp_alu_op1(dp_alu_op1), .dp_alu_op2(dp_alu_op2), .dp_bjp_op1(dp_bjp_op1),
    .dp_bjp_op2(dp_bjp_op2), .dp_lsu_op1(dp_lsu_op1), .dp_lsu_op2(dp_lsu_op2),
    .dp_qiu_op1(dp_qiu_op1), .dp_qiu_op2(dp_qiu_op2),
    .dp_alu_add(dp_alu_add), .dp_alu_sub(dp_alu_sub), .dp_alu_or(dp_alu_or),
    .dp_alu_xor(dp_alu_xor), .dp_alu_and(dp_alu_and),
    .dp_bjp_cmp_eq(dp_bjp_cmp_eq), .dp_bjp_cmp_ne(dp_bjp_cmp_ne),
    .dp_bjp_cmp_lt(dp_bjp_cmp_lt), .dp_bjp_cmp_gt(dp_bjp_cmp_gt),
    .dp_alu_res(dp_alu_res), .dp_lsu_res(dp_lsu_res), .dp_qiu_res(dp_qiu_res),
    .dp_bjp_cmp_res(dp_bjp_cmp_res), .dbg_rr_ptr(dbg_rr_ptr)
  );

  qpu_exu_alu_arbiter #(.XLEN(XLEN), .ARB_MODE(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .alu_i_valid(alu_i_valid), .alu_i_ready(f_rdy[0]), .alu_i_op1(alu_i_op1),
    .alu_i_op2(alu_i_op2), .alu_i_opsel(alu_i_opsel),
    .bjp_i_valid(bjp_i_valid), .bjp_i_ready(f_rdy[1]), .bjp_i_op1(bjp_i_op1),
    .bjp_i_op2(bjp_i_op2), .bjp_i_cmp(bjp_i_cmp),
    .lsu_i_valid(lsu_i_valid), .lsu_i_ready(f_rdy[2]), .lsu_i_op1(lsu_i_op1),
    .lsu_i_op2(lsu_i_op2),
    .qiu_i_valid(qiu_i_valid), .qiu_i_ready(f_rdy[3]), .qiu_i_op1(qiu_i_op1),
    .qiu_i_op2(qiu_i_op2),
    .alu_o_valid(f_ov[0]), .alu_o_res(f_res[0]), .alu_o_ready(alu_o_ready),
    .bjp_o_valid(f_ov[1]), .bjp_o_res(f_bjp_res), .bjp_o_ready(bjp_o_ready),
    .lsu_o_valid(f_ov[2]), .lsu_o_res(f_res[1]), .lsu_o_ready(lsu_o_ready),
    .qiu_o_valid(f_ov[3]), .qiu_o_res(f_res[2]), .qiu_o_ready(qiu_o_ready),
    .dp_alu_req(f_req[0]), .dp_bjp_req(f_req[1]), .dp_lsu_req(f_req[2]),
    .dp_qiu_req(f_req[3]),
    .dp_alu_op1(f_op1[0]), .dp_alu_op2(f_op2[0]), .dp_bjp_op1(f_op1[1]),
    .dp_bjp_op2(f_op2[1]), .dp_lsu_op1(f_op1[2]), .dp_lsu_op2(f_op2[2]),
    .dp_qiu_op1(f_op1[3]), .dp_qiu_op2(f_op2[3]),
    .dp_alu_add(f_alu_ctl[4]), .dp_alu_sub(f_alu_ctl[3]), .dp_alu_or(f_alu_ctl[2]),
    .dp_alu_xor(f_alu_ctl[1]), .dp_alu_and(f_alu_ctl[0]),
    .dp_bjp_cmp_eq(f_cmp_ctl[3]), .dp_bjp_cmp_ne(f_cmp_ctl[2]),
    .dp_bjp_cmp_lt(f_cmp_ctl[1]), .dp_bjp_cmp_gt(f_cmp_ctl[0]),
    .dp_alu_res('0), .dp_lsu_res('0), .dp_qiu_res('0),
    .dp_bjp_cmp_res(1'b0), .dbg_rr_ptr(f_dbg)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [XLEN-1:0] ref_alu(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [4:0] sel);
    case (sel)
      5'b10000: return a + b;
      5'b01000: return a - b;
      5'b00100: return a | b;
      5'b00010: return a ^ b;
      5'b00001: return a & b;
      default:  return '0;
    endcase
  endfunction

  function automatic logic ref_cmp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [3:0] sel);
    case (sel)
      4'b1000: return a == b;
      4'b0100: return a != b;
      4'b0010: return $signed(a) < $signed(b);
      4'b0001: return !($signed(a) < $signed(b));
      default: return 1'b0;
    endcase
  endfunction

  // Round-robin: first eligible requester walking ALU,BJP,LSU,QIU from the pointer.
  function automatic int pick_rr(input logic [3:0] elig, input int ptr);
    for (int k = 0; k < 4; k++) if (elig[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [3:0] v);
    {qiu_i_valid, lsu_i_valid, bjp_i_valid, alu_i_valid} = v;
  endtask

  task automatic set_oready(input logic [3:0] r);
    {qiu_o_ready, lsu_o_ready, bjp_o_ready, alu_o_ready} = r;
  endtask

  task automatic set_idle();
    set_valid(4'h0);
    set_oready(4'hF);
    alu_i_op1 = '0; alu_i_op2 = '0; bjp_i_op1 = '0; bjp_i_op2 = '0;
    lsu_i_op1 = '0; lsu_i_op2 = '0; qiu_i_op1 = '0; qiu_i_op2 = '0;
    alu_i_opsel = '0; bjp_i_cmp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    set_valid(4'hF);
    #1;
    n_checks++; if (rdy !== 4'h0) begin n_errors++; $display("FAIL reset_no_grant: got %b expected 0000", rdy); end
    tick();
    rst = 1'b0;
    set_valid(4'h0);
    #1;
    n_checks++; if (ov !== 4'h0) begin n_errors++; $display("FAIL reset_o_valid: got %b expected 0000", ov); end
    n_checks++; if ({alu_o_res, lsu_o_res, qiu_o_res, bjp_o_res} !== '0) begin
      n_errors++; $display("FAIL reset_o_res: got %h %h %h %b expected zeros", alu_o_res, lsu_o_res, qiu_o_res, bjp_o_res); end
    n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL reset_ptr: got %0d expected 0", dbg_rr_ptr); end
    n_checks++; if ({rdy, dp_alu_req, dp_lsu_op1} !== '0) begin
      n_errors++; $display("FAIL idle_outputs: got rdy=%b req=%b op=%h expected zeros", rdy, dp_alu_req, dp_lsu_op1); end
  endtask

  task automatic test_alu_add();
    set_idle();
    alu_i_op1 = 5; alu_i_op2 = 7; alu_i_opsel = 5'b10000; alu_i_valid = 1'b1;
    #1;
    n_checks++; if (rdy !== 4'b0001) begin n_errors++; $display("FAIL alu_add_ready: got %b expected 0001", rdy); end
    n_checks++; if ({dp_alu_req, dp_alu_add, dp_alu_sub} !== 3'b110) begin
      n_errors++; $display("FAIL alu_add_dp_ctl: got %b expected 110", {dp_alu_req, dp_alu_add, dp_alu_sub}); end
    tick();
    alu_i_valid = 1'b0;
    n_checks++; if (alu_o_valid !== 1'b1) begin n_errors++; $display("FAIL alu_add_valid: got %b expected 1", alu_o_valid); end
    n_checks++; if (alu_o_res !== 32'd12) begin n_errors++; $display("FAIL alu_add_res: got %0d expected 12", alu_o_res); end
    tick();
    n_checks++; if (alu_o_valid !== 1'b0) begin n_errors++; $display("FAIL alu_add_drain: got %b expected 0", alu_o_valid); end
  endtask

  task automatic test_rr_order();
    logic [3:0] v, g, exp_g;
    do_reset();
    set_idle();
    alu_i_opsel = 5'b10000; bjp_i_cmp = 4'b1000;
    v = 4'hF;
    set_valid(v);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g = 4'b0001 << i;
      n_checks++; if (rdy !== exp_g) begin n_errors++; $display("FAIL rr_grant_%0d: got %b expected %b", i, rdy, exp_g); end
      g = rdy;
      tick();
      v = v & ~g;
      set_valid(v);
    end
    n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_errors++; $display("FAIL rr_ptr_wrap: got %0d expected 0", dbg_rr_ptr); end
  endtask

  task automatic test_fixed_order();
    int order[4] = '{1, 3, 2, 0};
    logic [XLEN-1:0] in_op1[4];
    logic [XLEN-1:0] others;
    logic [8:0] exp_ctl;
    logic [3:0] v, g, exp_g;
    do_reset();
    set_idle();
    alu_i_op1 = 5; alu_i_op2 = 6; alu_i_opsel = 5'b10000;
    bjp_i_op1 = 9; bjp_i_op2 = 9; bjp_i_cmp = 4'b1000;
    lsu_i_op1 = 1; lsu_i_op2 = 2; qiu_i_op1 = 3; qiu_i_op2 = 4;
    in_op1 = '{alu_i_op1, bjp_i_op1, lsu_i_op1, qiu_i_op1};
    v = 4'hF;
    set_valid(v);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_g = 4'b0001 << order[i];
      n_checks++; if (f_rdy !== exp_g || f_req !== exp_g) begin
        n_errors++; $display("FAIL fixed_grant_%0d: got ready=%b req=%b expected %b", i, f_rdy, f_req, exp_g); end
      others = '0;
      for (int r = 0; r < 4; r++) if (r != order[i]) others = others | f_op1[r] | f_op2[r];
      n_checks++; if (f_op1[order[i]] !== in_op1[order[i]] || others !== '0) begin
        n_errors++; $display("FAIL fixed_operands_%0d: got op1=%h others=%h expected %h and 0", i, f_op1[order[i]], others, in_op1[order[i]]); end
      exp_ctl = (order[i] == 0) ? {alu_i_opsel, 4'b0} : (order[i] == 1) ? {5'b0, bjp_i_cmp} : 9'b0;
      n_checks++; if ({f_alu_ctl, f_cmp_ctl} !== exp_ctl) begin
        n_errors++; $display("FAIL fixed_ctl_%0d: got %b expected %b", i, {f_alu_ctl, f_cmp_ctl}, exp_ctl); end
      g = f_rdy;
      tick();
      v = v & ~g;
      set_valid(v);
    end
    n_checks++; if (f_ov !== 4'b0001 || {f_res[0], f_res[1], f_res[2], f_bjp_res} !== '0 || f_dbg !== 2'd0) begin
      n_errors++; $display("FAIL fixed_tail: got ov=%b res0=%h ptr=%0d expected 0001 0 0", f_ov, f_res[0], f_dbg); end
  endtask

  task automatic test_backpressure();
    set_idle();
    lsu_o_ready = 1'b0;
    lsu_i_op1 = 32'h100; lsu_i_op2 = 32'h20; lsu_i_valid = 1'b1;
    #1;
    n_checks++; if (lsu_i_ready !== 1'b1) begin n_errors++; $display("FAIL bp_first_ready: got %b expected 1", lsu_i_ready); end
    tick();
    lsu_i_op1 = 32'h5; lsu_i_op2 = 32'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (lsu_i_ready !== 1'b0) begin n_errors++; $display("FAIL bp_stall_ready_%0d: got %b expected 0", i, lsu_i_ready); end
      n_checks++; if (lsu_o_valid !== 1'b1 || lsu_o_res !== 32'h120) begin
        n_errors++; $display("FAIL bp_hold_%0d: got valid=%b res=%h expected 1 120", i, lsu_o_valid, lsu_o_res); end
      tick();
    end
    lsu_o_ready = 1'b1;
    #1;
    n_checks++; if (lsu_i_ready !== 1'b1) begin n_errors++; $display("FAIL bp_refill_ready: got %b expected 1", lsu_i_ready); end
    tick();
    lsu_i_valid = 1'b0;
    n_checks++; if (lsu_o_valid !== 1'b1 || lsu_o_res !== 32'hB) begin
      n_errors++; $display("FAIL bp_refill_res: got valid=%b res=%h expected 1 b", lsu_o_valid, lsu_o_res); end
    tick();
    n_checks++; if (lsu_o_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b expected 0", lsu_o_valid); end
  endtask

  task automatic test_back_to_back();
    set_idle();
    qiu_i_op1 = 1; qiu_i_op2 = 1; qiu_i_valid = 1'b1;
    #1;
    n_checks++; if (qiu_i_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_1: got %b expected 1", qiu_i_ready); end
    tick();
    qiu_i_op1 = 2; qiu_i_op2 = 2;
    n_checks++; if (qiu_o_valid !== 1'b1 || qiu_o_res !== 32'd2) begin
      n_errors++; $display("FAIL b2b_res_1: got valid=%b res=%0d expected 1 2", qiu_o_valid, qiu_o_res); end
    #1;
    n_checks++; if (qiu_i_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_2: got %b expected 1", qiu_i_ready); end
    tick();
    qiu_i_valid = 1'b0;
    n_checks++; if (qiu_o_valid !== 1'b1 || qiu_o_res !== 32'd4) begin
      n_errors++; $display("FAIL b2b_res_2: got valid=%b res=%0d expected 1 4", qiu_o_valid, qiu_o_res); end
    tick();
    n_checks++; if (qiu_o_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain: got %b expected 0", qiu_o_valid); end
  endtask

  task automatic test_bjp_compare();
    logic [3:0]      c_cmp[4] = '{4'b0010, 4'b0001, 4'b1000, 4'b0100};
    logic [XLEN-1:0] c_a[4]   = '{32'hFFFF_FFFF, 32'd3, 32'd3, 32'd3};
    logic [XLEN-1:0] c_b[4]   = '{32'd1, 32'd3, 32'd4, 32'd4};
    logic            c_exp[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    set_idle();
    for (int i = 0; i < 4; i++) begin
      bjp_i_cmp = c_cmp[i]; bjp_i_op1 = c_a[i]; bjp_i_op2 = c_b[i]; bjp_i_valid = 1'b1;
      tick();
      bjp_i_valid = 1'b0;
      n_checks++; if (bjp_o_valid !== 1'b1 || bjp_o_res !== c_exp[i]) begin
        n_errors++; $display("FAIL bjp_cmp_%0d: got valid=%b res=%b expected 1 %b", i, bjp_o_valid, bjp_o_res, c_exp[i]); end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_idle();
    set_oready(4'b1010);
    alu_i_op1 = 1; alu_i_op2 = 2; alu_i_opsel = 5'b10000; alu_i_valid = 1'b1;
    tick();
    alu_i_valid = 1'b0;
    lsu_i_op1 = 4; lsu_i_op2 = 4; lsu_i_valid = 1'b1;
    tick();
    lsu_i_valid = 1'b0;
    n_checks++; if (ov !== 4'b0101) begin n_errors++; $display("FAIL mid_pending: got %b expected 0101", ov); end
    rst = 1'b1;
    set_valid(4'hF);
    #1;
    n_checks++; if (rdy !== 4'h0) begin n_errors++; $display("FAIL mid_rst_no_grant: got %b expected 0000", rdy); end
    tick();
    rst = 1'b0;
    n_checks++; if (ov !== 4'h0 || dbg_rr_ptr !== 2'd0) begin
      n_errors++; $display("FAIL mid_rst_state: got ov=%b ptr=%0d expected 0000 0", ov, dbg_rr_ptr); end
    set_oready(4'hF);
    #1;
    n_checks++; if (rdy !== 4'b0001) begin n_errors++; $display("FAIL mid_alu_first: got %b expected 0001", rdy); end
    tick();
    set_valid(4'h0);
    tick();
  endtask

  task automatic test_random();
    logic            m_valid[4];
    logic [XLEN-1:0] m_res[4];
    logic [XLEN-1:0] obs_res[4];
    logic [XLEN-1:0] a[4];
    logic [XLEN-1:0] b[4];
    logic [3:0] v, ordy, busy, elig, exp_g, got_ov;
    int m_ptr, g;
    do_reset();
    set_idle();
    m_ptr = 0;
    for (int r = 0; r < 4; r++) begin m_valid[r] = 1'b0; m_res[r] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 4; r++) begin
        v[r]    = ($urandom_range(0, 2) != 0);
        ordy[r] = ($urandom_range(0, 3) != 0);
        a[r] = $urandom_range(0, 1) ? $urandom : XLEN'($urandom_range(0, 8));
        b[r] = $urandom_range(0, 1) ? $urandom : XLEN'($urandom_range(0, 8));
      end
      alu_i_op1 = a[0]; alu_i_op2 = b[0]; bjp_i_op1 = a[1]; bjp_i_op2 = b[1];
      lsu_i_op1 = a[2]; lsu_i_op2 = b[2]; qiu_i_op1 = a[3]; qiu_i_op2 = b[3];
      alu_i_opsel = 5'b00001 << $urandom_range(0, 4);
      bjp_i_cmp   = 4'b0001 << $urandom_range(0, 3);
      set_valid(v);
      set_oready(ordy);
      #1;
      for (int r = 0; r < 4; r++) busy[r] = m_valid[r] && !ordy[r];
      elig = v & ~busy;
      g = pick_rr(elig, m_ptr);
      exp_g = (g < 0) ? 4'b0 : (4'b0001 << g);
      n_checks++; if (rdy !== exp_g) begin
        n_errors++; $display("FAIL rand_grant cyc%0d: got %b expected %b", cyc, rdy, exp_g); end
      for (int r = 0; r < 4; r++) begin
        if (r == g) begin
          m_valid[r] = 1'b1;
          case (r)
            0:       m_res[r] = ref_alu(a[0], b[0], alu_i_opsel);
            1:       m_res[r] = {{(XLEN-1){1'b0}}, ref_cmp(a[1], b[1], bjp_i_cmp)};
            default: m_res[r] = a[r] + b[r];
          endcase
        end else if (ordy[r]) begin
          m_valid[r] = 1'b0;
        end
      end
      if (g >= 0) m_ptr = (g + 1) % 4;
      tick();
      obs_res = '{alu_o_res, {{(XLEN-1){1'b0}}, bjp_o_res}, lsu_o_res, qiu_o_res};
      for (int r = 0; r < 4; r++) got_ov[r] = m_valid[r];
      n_checks++; if (ov !== got_ov) begin
        n_errors++; $display("FAIL rand_valid cyc%0d: got %b expected %b", cyc, ov, got_ov); end
      for (int r = 0; r < 4; r++) begin
        if (m_valid[r]) begin
          n_checks++; if (obs_res[r] !== m_res[r]) begin
            n_errors++; $display("FAIL rand_res%0d cyc%0d: got %h expected %h", r, cyc, obs_res[r], m_res[r]); end
        end
      end
    end
    set_idle();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_alu_add();
    test_rr_order();
    test_fixed_order();
    test_backpressure();
    test_back_to_back();
    test_bjp_compare();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
